serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 113 +++++++++++
 tb/tb_serial_add_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving an external 1-bit full adder
//
// Purpose:
//   Captures two WIDTH-bit operands plus a carry-in, feeds them LSB-first to an
//   external combinational full adder one bit per clock, keeps the running carry
//   in a flip-flop and assembles the returned sum bits. The finished sum and
//   carry-out are presented with a one-cycle done pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        operation request, sampled only in IDLE
//   a_in, b_in   operands, captured when start is accepted
//   ci_in        initial carry-in, captured when start is accepted
//   fa_a, fa_b   operand bits to the full adder (0 outside SHIFT)
//   fa_ci        carry bit to the full adder (0 outside SHIFT)
//   fa_s, fa_co  sum and carry returned by the full adder, same cycle
//   busy         high while bits are being shifted
//   done         one-cycle pulse; sum/co_out valid from this cycle onward
//   sum, co_out  result word and final carry-out, held until the next result

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ci_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            co_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= ci_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Final bit goes straight into the output word so the
                        // result is visible in the DONE cycle.
                        sum    <= {fa_s, sum_sr[WIDTH-1:1]};
                        co_out <= fa_co;
                        state  <= DONE;
                    end else begin
                        sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Full-adder drive is gated by state so the cell sees zeros when idle.
    always_comb begin
        busy  = (state == SHIFT);
        done  = (state == DONE);
        fa_a  = busy & a_sr[0];
        fa_b  = busy & b_sr[0];
        fa_ci = busy & carry;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl with scoreboard
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ci_in;
    logic             fa_a, fa_b, fa_ci;
    logic             fa_s, fa_co;
    logic             busy, done;
    logic [WIDTH-1:0] sum;
    logic             co_out;

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] hold_val;
    logic           prev_done;

    always #5 clk = ~clk;

    // External combinational full adder cell.
    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .ci_in  (ci_in),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_ci  (fa_ci),
        .fa_s   (fa_s),
        .fa_co  (fa_co),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .co_out (co_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic c);
        logic [WIDTH:0] r;
        r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        return r;
    endfunction

    // Scoreboard monitor: pops on each done, checks pulse width and that the
    // result stays put between pulses.
    always @(negedge clk) begin
        if (rst) begin
            hold_val  = '0;
            prev_done = 1'b0;
        end else begin
            total++;
            if (done === 1'b1 && prev_done === 1'b1) begin
                bad++;
                $display("FAIL done_width: done high in consecutive cycles, got 2+ cycles, want 1");
            end
            if (done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got done with {co,sum}=%h, want no result pending", {co_out, sum});
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    if ({co_out, sum} !== e) begin
                        bad++;
                        $display("FAIL result: got {co,sum}=%h, want %h", {co_out, sum}, e);
                    end
                end
                hold_val = {co_out, sum};
            end else if ({co_out, sum} !== hold_val) begin
                bad++;
                $display("FAIL sum_stable: got {co,sum}=%h, want held %h", {co_out, sum}, hold_val);
                hold_val = {co_out, sum};
            end
            prev_done = done;
        end
    end

    // Issue one operation and wait until the controller is idle again.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        ci_in = c;
        exp_q.push_back(ref_add(a, b, c));
        tick();
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        ci_in = ~c;
        repeat (WIDTH + 1) tick();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        ci_in = 1'b1;
        tick();
        tick();
        total++;
        if ({sum, co_out, busy, done, fa_a, fa_b, fa_ci} !== '0) begin
            bad++;
            $display("FAIL reset_state: got sum=%h co=%b busy=%b done=%b fa=%b%b%b, want all 0",
                     sum, co_out, busy, done, fa_a, fa_b, fa_ci);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_beats_start: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_latency();
        int busy_cnt;
        busy_cnt = 0;
        start = 1'b1;
        a_in  = 8'h00;
        b_in  = 8'h00;
        ci_in = 1'b0;
        exp_q.push_back(ref_add(8'h00, 8'h00, 1'b0));
        tick();
        start = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            if (busy === 1'b1 && done === 1'b0) busy_cnt++;
            tick();
        end
        total++;
        if (busy_cnt != WIDTH) begin
            bad++;
            $display("FAIL busy_cycles: got %0d, want %0d", busy_cnt, WIDTH);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_latency: got done=%b busy=%b at edge %0d, want done=1 busy=0", done, busy, WIDTH + 1);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL back_to_idle: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_carry_chain();
        logic [WIDTH-1:0] a, b;
        logic prev_co;
        a = 8'hFF;
        b = 8'h01;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        ci_in = 1'b0;
        exp_q.push_back(ref_add(a, b, 1'b0));
        tick();
        start = 1'b0;
        prev_co = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            total++;
            if (fa_ci !== prev_co || fa_a !== a[i] || fa_b !== b[i]) begin
                bad++;
                $display("FAIL fa_drive bit %0d: got a=%b b=%b ci=%b, want a=%b b=%b ci=%b",
                         i, fa_a, fa_b, fa_ci, a[i], b[i], prev_co);
            end
            prev_co = fa_co;
            tick();
        end
        total++;
        if ({fa_a, fa_b, fa_ci} !== 3'b000) begin
            bad++;
            $display("FAIL fa_idle: got fa=%b%b%b in DONE, want 000", fa_a, fa_b, fa_ci);
        end
        tick();
    endtask

    task automatic test_patterns();
        run_op(8'hA5, 8'h5A, 1'b1);
        run_op(8'h3C, 8'h42, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h80, 8'h80, 1'b0);
    endtask

    task automatic test_ignore_start();
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        ci_in = 1'b0;
        exp_q.push_back(ref_add(8'h12, 8'h34, 1'b0));
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        tick();
        start = 1'b0;
        tick();
        a_in  = 8'h77;
        b_in  = 8'h99;
        ci_in = 1'b1;
        repeat (WIDTH - 4) tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL ignore_done_cycle: got done=%b, want 1", done);
        end
        start = 1'b1;
        a_in  = 8'h0F;
        b_in  = 8'h01;
        ci_in = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: got busy=%b done=%b, want 0 0", busy, done);
        end
        exp_q.push_back(ref_add(8'h0F, 8'h01, 1'b0));
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL accept_after_idle: got busy=%b, want 1", busy);
        end
        start = 1'b0;
        repeat (WIDTH + 1) tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h01;
        ci_in = 1'b0;
        exp_q.push_back(ref_add(8'hFF, 8'h01, 1'b0));
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        total++;
        if ({sum, co_out, busy, done, fa_a, fa_b, fa_ci} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got sum=%h co=%b busy=%b done=%b fa=%b%b%b, want all 0",
                     sum, co_out, busy, done, fa_a, fa_b, fa_ci);
        end
        for (int i = 0; i < WIDTH + 2; i++) begin
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_discard cycle %0d: got done=%b busy=%b, want 0 0", i, done, busy);
            end
            tick();
        end
        run_op(8'h01, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b;
        logic c;
        start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            c = 1'($urandom);
            a_in  = a;
            b_in  = b;
            ci_in = c;
            exp_q.push_back(ref_add(a, b, c));
            tick();
            for (int k = 0; k < WIDTH + 1; k++) begin
                a_in  = WIDTH'($urandom);
                b_in  = WIDTH'($urandom);
                ci_in = 1'($urandom);
                tick();
            end
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        ci_in = 1'b0;
        test_reset();
        test_latency();
        test_carry_chain();
        test_patterns();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_results: got %0d outstanding, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
